// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter, one adjust+shift step per clock.
// Define BIN2BCD_OVF_CHECK_EN to compile in the sticky overflow flag.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [BIN_W-1:0]    bin_r, bin_s;
    logic [BCD_W-1:0]    bcd_r, bcd_s, adj_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                accept_s;
    logic                shift_s;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    assign adj_s = dabble_adjust(bcd_r);

    // Next-state and datapath update; the top bit of the adjusted BCD falls off on each shift.
    always_comb begin
        state_s  = state_r;
        bin_s    = bin_r;
        bcd_s    = bcd_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        shift_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    bin_s    = bin;
                    bcd_s    = {BCD_W{1'b0}};
                    cnt_s    = CNT_W'(BIN_W);
                    state_s  = SHIFT;
                end else begin
                    state_s  = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                bcd_s   = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
                bin_s   = bin_r << 1'b1;
                cnt_s   = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            bin_r   <= {BIN_W{1'b0}};
            bcd_r   <= {BCD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            bin_r   <= bin_s;
            bcd_r   <= bcd_s;
            cnt_r   <= cnt_s;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign bcd       = bcd_r;

`ifdef BIN2BCD_OVF_CHECK_EN
    logic ovf_r;

    // Sticky flag: any 1 discarded from the top digit means the value did not fit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if (shift_s && adj_s[BCD_W-1]) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign overflow = ovf_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ^{adj_s[BCD_W-1], shift_s, accept_s};
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, exhaustive and randomized runs
// against an arithmetic decimal model, backpressure and mid-conversion reset.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_OVF_CHECK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] bin_g = 16'd0;
    int sel = 0;

    logic a_in_ready, a_out_valid, a_ovf;
    logic [11:0] a_bcd;
    logic b_in_ready, b_out_valid, b_ovf;
    logic [7:0] b_bcd;
    logic c_in_ready, c_out_valid, c_ovf;
    logic [19:0] c_bcd;

    logic cur_in_ready, cur_out_valid, cur_ovf;
    logic [19:0] cur_bcd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(a_in_ready),
        .bin(bin_g[7:0]), .out_valid(a_out_valid), .out_ready(out_ready && sel == 0),
        .bcd(a_bcd), .overflow(a_ovf));

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(b_in_ready),
        .bin(bin_g[7:0]), .out_valid(b_out_valid), .out_ready(out_ready && sel == 1),
        .bcd(b_bcd), .overflow(b_ovf));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(c_in_ready),
        .bin(bin_g), .out_valid(c_out_valid), .out_ready(out_ready && sel == 2),
        .bcd(c_bcd), .overflow(c_ovf));

    always_comb begin
        cur_in_ready  = a_in_ready;
        cur_out_valid = a_out_valid;
        cur_ovf       = a_ovf;
        cur_bcd       = {8'h00, a_bcd};
        if (sel == 1) begin
            cur_in_ready  = b_in_ready;
            cur_out_valid = b_out_valid;
            cur_ovf       = b_ovf;
            cur_bcd       = {12'h000, b_bcd};
        end else if (sel == 2) begin
            cur_in_ready  = c_in_ready;
            cur_out_valid = c_out_valid;
            cur_ovf       = c_ovf;
            cur_bcd       = c_bcd;
        end
    end

    // Reference: value mod 10^digits, split into decimal digits by plain arithmetic.
    function automatic logic [19:0] ref_bcd(input longint v, input int d);
        longint m = 1;
        longint r;
        logic [19:0] res = 20'h00000;
        for (int i = 0; i < d; i++) m = m * 10;
        r = v % m;
        for (int i = 0; i < d; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic ref_ovf(input longint v, input int d);
        longint m = 1;
        for (int i = 0; i < d; i++) m = m * 10;
        return OVF_EN && (v >= m);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present v to the selected DUT and wait for its result (out_ready untouched).
    task automatic convert(input logic [15:0] v, output logic [19:0] res, output logic ovf,
                           output int lat);
        int n = 0;
        while (!cur_in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("ready_timeout", 32'(n >= 100), 32'd0);
        in_valid = 1'b1;
        bin_g = v;
        @(posedge clk); #1;
        last_accept = cyc;
        in_valid = 1'b0;
        bin_g = 16'($urandom);
        lat = 0;
        while (!cur_out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("valid_timeout", 32'(lat >= 100), 32'd0);
        res = cur_bcd;
        ovf = cur_ovf;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", 32'(cur_out_valid), 32'd0);
        check("post_hs_ready", 32'(cur_in_ready), 32'd1);
    endtask

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        int          sel;
        int          lat;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [19:0] res;
        logic ovf;
        int lat;
        int prev;
        logic [15:0] v;

        tbl[0] = '{16'd255,   20'h00255, 0, 8,  1'b0};
        tbl[1] = '{16'd0,     20'h00000, 0, 8,  1'b0};
        tbl[2] = '{16'd9,     20'h00009, 0, 8,  1'b0};
        tbl[3] = '{16'd100,   20'h00100, 0, 8,  1'b0};
        tbl[4] = '{16'd99,    20'h00099, 1, 8,  1'b0};
        tbl[5] = '{16'd200,   20'h00000, 1, 8,  OVF_EN};
        tbl[6] = '{16'd65535, 20'h65535, 2, 16, 1'b0};
        tbl[7] = '{16'd10,    20'h00010, 2, 16, 1'b0};

        #2;
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_bcd", 32'(a_bcd), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            sel = tbl[i].sel;
            convert(tbl[i].bin, res, ovf, lat);
            check("tbl_bcd", 32'(res), 32'(tbl[i].bcd));
            check("tbl_ovf", 32'(ovf), 32'(tbl[i].ovf));
            check("tbl_latency", 32'(lat), 32'(tbl[i].lat));
            release_result();
        end

        // Exhaustive back-to-back with out_ready held high: one result per 10 cycles.
        sel = 0;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            convert(16'(i), res, ovf, lat);
            check("exh_bcd", 32'(res), 32'(ref_bcd(longint'(i), 3)));
            if (i > 0) check("exh_period", 32'(last_accept - prev), 32'd10);
            prev = last_accept;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Backpressure on 137 with ignored input pulses.
        convert(16'd137, res, ovf, lat);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            bin_g = 16'($urandom_range(0, 255));
            @(posedge clk); #1;
            check("bp_bcd", 32'(a_bcd), 32'h137);
            check("bp_valid", 32'(a_out_valid), 32'd1);
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_result();
        convert(16'd77, res, ovf, lat);
        check("after_bp_bcd", 32'(res), 32'h077);
        release_result();

        // Reset at step 4 of converting 200.
        in_valid = 1'b1;
        bin_g = 16'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(a_out_valid), 32'd0);
        check("midrst_bcd", 32'(a_bcd), 32'd0);
        check("midrst_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        convert(16'd42, res, ovf, lat);
        check("postrst_bcd", 32'(res), 32'h042);
        check("postrst_latency", 32'(lat), 32'd8);
        release_result();

        // Randomized runs against the model on all three widths, with random stalls.
        for (int i = 0; i < 60; i++) begin
            sel = i % 3;
            v = (sel == 2) ? 16'($urandom) : 16'($urandom_range(0, 255));
            convert(v, res, ovf, lat);
            check("rnd_bcd", 32'(res), 32'(ref_bcd(longint'(v), sel == 0 ? 3 : (sel == 1 ? 2 : 5))));
            check("rnd_ovf", 32'(ovf), 32'(ref_ovf(longint'(v), sel == 0 ? 3 : (sel == 1 ? 2 : 5))));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check("rnd_hold", 32'(cur_bcd), 32'(res));
            end
            release_result();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete (checks %0d)", checks);
        $fatal(1);
    end

endmodule
